// File: rtl/led_pwm_bank.sv
// led_pwm_bank: memory-mapped LED controller. Each channel is off, on, PWM-dimmed
// or blinking. All channels share one prescaled PWM timebase, and duty values are
// double-buffered so that a new duty only lands on a period boundary.
module led_pwm_bank #(
  parameter int N_CH    = 8,
  parameter int DUTY_W  = 8,
  parameter int PRESC_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cs,
  input  logic            we,
  input  logic [31:0]     a,
  input  logic [31:0]     wd,
  output logic [31:0]     rd,
  output logic [N_CH-1:0] led
);

  // Bus-visible registers
  logic                r_en;
  logic [PRESC_W-1:0]  r_presc;
  logic [2*N_CH-1:0]   r_mode;
  logic [15:0]         r_blink;
  logic [DUTY_W-1:0]   r_duty [N_CH];

  // Timebase, shadows and output state
  logic [DUTY_W-1:0]   r_dsh [N_CH];
  logic [PRESC_W-1:0]  r_psc;
  logic [DUTY_W-1:0]   r_pc;
  logic [15:0]         r_bc;
  logic                r_phase;
  logic                r_run;
  logic [N_CH-1:0]     r_led;

  logic [3:0]          w_off;
  logic                w_wr;
  logic                w_tick;
  logic                w_wrap;
  logic                w_load;
  logic [N_CH-1:0]     w_next;
  logic [DUTY_W-1:0]   w_duty_rd;
  logic                w_unused;

  assign w_off  = a[5:2];
  assign w_wr   = cs & we;
  assign w_tick = (r_psc == r_presc);
  assign w_wrap = w_tick & (r_pc == {DUTY_W{1'b1}});
  // The first enabled clock reloads the shadows just like a period boundary.
  assign w_load = w_wrap | ~r_run;
  assign led    = r_led;
  // Address bits outside the word offset and unused data bits are ignored.
  assign w_unused = ^{a[31:6], a[1:0], wd};

  // Control, prescale, mode and blink registers: written on cs & we.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en    <= 1'b0;
      r_presc <= {PRESC_W{1'b0}};
      r_mode  <= {(2*N_CH){1'b0}};
      r_blink <= 16'd0;
    end else if (w_wr) begin
      case (w_off)
        4'd0:    r_en    <= wd[0];
        4'd1:    r_presc <= wd[PRESC_W-1:0];
        4'd2:    r_mode  <= wd[2*N_CH-1:0];
        4'd3:    r_blink <= wd[15:0];
        default: r_en    <= r_en;
      endcase
    end
  end

  // Duty registers: one per channel at word offsets 4 upward.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) r_duty[i] <= {DUTY_W{1'b0}};
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (w_wr && (w_off == (4'd4 + 4'(i)))) r_duty[i] <= wd[DUTY_W-1:0];
      end
    end
  end

  // Shared timebase: prescaler, PWM counter, blink counter and phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_psc   <= {PRESC_W{1'b0}};
      r_pc    <= {DUTY_W{1'b0}};
      r_bc    <= 16'd0;
      r_phase <= 1'b0;
      r_run   <= 1'b0;
    end else if (!r_en) begin
      r_psc   <= {PRESC_W{1'b0}};
      r_pc    <= {DUTY_W{1'b0}};
      r_bc    <= 16'd0;
      r_phase <= 1'b0;
      r_run   <= 1'b0;
    end else begin
      r_run <= 1'b1;
      // Using >= also restarts cleanly when PRESC is lowered below psc.
      r_psc <= (r_psc >= r_presc) ? {PRESC_W{1'b0}} : r_psc + PRESC_W'(1'b1);
      if (w_tick) r_pc <= r_pc + DUTY_W'(1'b1);
      if (w_wrap) begin
        if (r_bc == r_blink) begin
          r_bc    <= 16'd0;
          r_phase <= ~r_phase;
        end else begin
          r_bc <= r_bc + 16'd1;
        end
      end
    end
  end

  // Duty shadows: sample the bus-side duty only on a period boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) r_dsh[i] <= {DUTY_W{1'b0}};
    end else if (!r_en) begin
      for (int i = 0; i < N_CH; i++) r_dsh[i] <= {DUTY_W{1'b0}};
    end else if (w_load) begin
      for (int i = 0; i < N_CH; i++) r_dsh[i] <= r_duty[i];
    end
  end

  // Per-channel next LED value from mode, PWM compare and blink phase.
  always_comb begin
    w_next = {N_CH{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      case (r_mode[2*i +: 2])
        2'b00:   w_next[i] = 1'b0;
        2'b01:   w_next[i] = 1'b1;
        2'b10:   w_next[i] = (r_pc < r_dsh[i]);
        2'b11:   w_next[i] = r_phase;
        default: w_next[i] = 1'b0;
      endcase
    end
  end

  // LED output register; forced dark while disabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_led <= {N_CH{1'b0}};
    end else if (!r_en) begin
      r_led <= {N_CH{1'b0}};
    end else begin
      r_led <= w_next;
    end
  end

  // Duty readback mux: OR of the single matching channel, 0 otherwise.
  always_comb begin
    w_duty_rd = {DUTY_W{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      w_duty_rd = w_duty_rd | ({DUTY_W{w_off == (4'd4 + 4'(i))}} & r_duty[i]);
    end
  end

  // Combinational read port; returns 0 when not selected or unmapped.
  always_comb begin
    rd = 32'd0;
    if (cs) begin
      case (w_off)
        4'd0:    rd[0]              = r_en;
        4'd1:    rd[PRESC_W-1:0]    = r_presc;
        4'd2:    rd[2*N_CH-1:0]     = r_mode;
        4'd3:    rd[15:0]           = r_blink;
        default: rd[DUTY_W-1:0]     = w_duty_rd;
      endcase
    end else begin
      rd = 32'd0;
    end
  end

endmodule

// File: tb/tb_led_pwm_bank.sv
// tb_led_pwm_bank: randomized and directed stimulus against an arithmetic
// reference model; expected values are queued and checked by a monitor.
module tb_led_pwm_bank;
  localparam int N_CH    = 8;
  localparam int DUTY_W  = 8;
  localparam int PRESC_W = 16;

  logic            clk   = 1'b0;
  logic            reset = 1'b0;
  logic            cs    = 1'b0;
  logic            we    = 1'b0;
  logic [31:0]     a     = 32'd0;
  logic [31:0]     wd    = 32'd0;
  logic [31:0]     rd;
  logic [N_CH-1:0] led;

  led_pwm_bank #(.N_CH(N_CH), .DUTY_W(DUTY_W), .PRESC_W(PRESC_W)) dut (
    .clk(clk), .reset(reset), .cs(cs), .we(we), .a(a), .wd(wd), .rd(rd), .led(led)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N_CH-1:0] led;
    logic [31:0]     rd;
    int              cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc_no   = 0;

  // Reference model state: register file plus enabled-clock count.
  bit              m_en;
  int              m_presc;
  int              m_blink;
  logic [15:0]     m_mode;
  int              m_duty [N_CH];
  int              m_dsh  [N_CH];
  int              m_k;
  logic [N_CH-1:0] m_led;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp, int c);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: actual=%h expected=%h", name, c, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_en = 1'b0; m_presc = 0; m_blink = 0; m_mode = 16'd0; m_k = 0; m_led = '0;
    for (int i = 0; i < N_CH; i++) begin
      m_duty[i] = 0;
      m_dsh[i]  = 0;
    end
  endfunction

  function automatic logic [31:0] model_rd(int off);
    case (off)
      0: return {31'd0, m_en};
      1: return 32'(m_presc);
      2: return {16'd0, m_mode};
      3: return 32'(m_blink);
      default: begin
        if (off >= 4 && off < 4 + N_CH) return 32'(m_duty[off-4]);
        else return 32'd0;
      end
    endcase
  endfunction

  // One clock edge of the model. After k enabled clocks: pc = (k/(P+1)) mod 256,
  // completed periods = k/(256(P+1)), blink phase = (periods/(B+1)) mod 2.
  function automatic void model_step(bit c, bit w, int off, logic [31:0] d);
    int per, pcb, phb;
    if (!reset) begin
      model_reset();
      return;
    end
    if (m_en) begin
      per = 256 * (m_presc + 1);
      pcb = (m_k / (m_presc + 1)) % 256;
      phb = ((m_k / per) / (m_blink + 1)) % 2;
      for (int i = 0; i < N_CH; i++) begin
        case (m_mode[2*i +: 2])
          2'b01:   m_led[i] = 1'b1;
          2'b10:   m_led[i] = (pcb < m_dsh[i]);
          2'b11:   m_led[i] = (phb == 1);
          default: m_led[i] = 1'b0;
        endcase
      end
      if (m_k == 0 || ((m_k + 1) % per) == 0) begin
        for (int i = 0; i < N_CH; i++) m_dsh[i] = m_duty[i];
      end
      m_k++;
    end else begin
      m_led = '0;
      m_k   = 0;
      for (int i = 0; i < N_CH; i++) m_dsh[i] = 0;
    end
    if (c && w) begin
      case (off)
        0: m_en    = d[0];
        1: m_presc = int'(d[15:0]);
        2: m_mode  = d[15:0];
        3: m_blink = int'(d[15:0]);
        default: if (off >= 4 && off < 4 + N_CH) m_duty[off-4] = int'(d[7:0]);
      endcase
    end
  endfunction

  // Drive one bus cycle, queue this cycle's expectation, advance the model.
  task automatic cyc(bit c, bit w, int off, logic [31:0] d);
    exp_t e;
    cs = c; we = w; wd = d;
    a  = ($urandom & 32'hFFFF_FFC3) | (32'(off) << 2);
    e.led = m_led;
    e.rd  = c ? model_rd(off) : 32'd0;
    e.cyc = cyc_no;
    sb_q.push_back(e);
    @(posedge clk);
    model_step(c, w, off, d);
    cyc_no++;
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) cyc(1'b0, 1'b0, 0, 32'd0);
  endtask

  // Count high cycles of led[2] over 256 clocks.
  task automatic count_period(int exp, string name);
    int cnt;
    cnt = 0;
    repeat (256) begin
      cyc(1'b0, 1'b0, 0, 32'd0);
      cnt += int'(led[2]);
    end
    chk(name, 32'(cnt), 32'(exp), cyc_no);
  endtask

  // Configure channel 2 for PWM with duty d, measure 4 full periods.
  task automatic pwm_run(int d);
    int cnt;
    cnt = 0;
    cyc(1'b1, 1'b1, 0, 32'd0);
    idle(2);
    cyc(1'b1, 1'b1, 1, 32'd0);
    cyc(1'b1, 1'b1, 6, 32'(d));
    cyc(1'b1, 1'b1, 2, 32'h20);
    cyc(1'b1, 1'b1, 0, 32'd1);
    idle(1);
    for (int n = 0; n < 1024; n++) begin
      cyc(1'b0, 1'b0, 0, 32'd0);
      cnt += int'(led[2]);
    end
    chk("pwm_high_count", 32'(cnt), 32'(4 * d), cyc_no);
  endtask

  // Monitor: compare whatever the stimulus queued for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("led", 32'(led), 32'(e.led), e.cyc);
        chk("rd", rd, e.rd, e.cyc);
      end
    end
  end

  initial begin
    int   r;
    exp_t e;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset values of every mapped register, LEDs dark.
    for (int o = 0; o < 12; o++) cyc(1'b1, 1'b0, o, 32'd0);
    idle(10);

    // Static on for channel 0, then disable.
    cyc(1'b1, 1'b1, 2, 32'h0000_0001);
    cyc(1'b1, 1'b1, 0, 32'h0000_0001);
    idle(4);
    cyc(1'b1, 1'b1, 0, 32'h0000_0000);
    idle(3);

    // PWM duty extremes and a mid value.
    pwm_run(0);
    pwm_run(255);
    pwm_run(64);

    // Mid-period duty write: current period keeps 64, next period is 200.
    while ((m_k % 256) != 100) idle(1);
    cyc(1'b1, 1'b1, 6, 32'd200);
    while ((m_k % 256) != 0) idle(1);
    count_period(200, "duty_next_period");
    // Duty write coinciding with a wrap lands one period later.
    while (((m_k + 1) % 256) != 0) idle(1);
    cyc(1'b1, 1'b1, 6, 32'd30);
    count_period(200, "wrap_write_old");
    count_period(30, "wrap_write_new");

    // Blink on channel 1 with half-period of two PWM periods.
    cyc(1'b1, 1'b1, 0, 32'd0);
    idle(2);
    cyc(1'b1, 1'b1, 1, 32'd0);
    cyc(1'b1, 1'b1, 3, 32'd1);
    cyc(1'b1, 1'b1, 2, 32'h0000_000C);
    cyc(1'b1, 1'b1, 0, 32'd1);
    idle(2100);

    // Randomized segments.
    for (int s = 0; s < 12; s++) begin
      cyc(1'b1, 1'b1, 0, $urandom & 32'hFFFF_FFFE);
      idle(2);
      cyc(1'b1, 1'b1, 1, {16'($urandom), 16'($urandom_range(0, 2))});
      cyc(1'b1, 1'b1, 3, {16'($urandom), 16'($urandom_range(0, 3))});
      cyc(1'b1, 1'b1, 2, $urandom);
      for (int i = 0; i < N_CH; i++) cyc(1'b1, 1'b1, 4 + i, $urandom);
      cyc(1'b1, 1'b1, 0, $urandom | 32'd1);
      repeat ($urandom_range(600, 1400)) begin
        r = $urandom_range(0, 99);
        if (r < 8)       cyc(1'b1, 1'b1, $urandom_range(4, 4 + N_CH - 1), $urandom);
        else if (r < 11) cyc(1'b1, 1'b1, 2, $urandom);
        else if (r < 13) cyc(1'b1, 1'b1, $urandom_range(12, 15), $urandom);
        else if (r < 33) cyc(1'b1, 1'b0, $urandom_range(0, 15), 32'd0);
        else if (r < 34) cyc(1'b1, 1'b1, 0, {31'($urandom), ~m_en});
        else if (r < 36 && !m_en) cyc(1'b1, 1'b1, 1, {16'($urandom), 16'($urandom_range(0, 2))});
        else             idle(1);
      end
    end

    // Asynchronous reset mid-PWM: outputs clear before any clock edge.
    cyc(1'b1, 1'b1, 0, 32'd0);
    idle(2);
    cyc(1'b1, 1'b1, 1, 32'd0);
    cyc(1'b1, 1'b1, 2, 32'h0000_AAAA);
    for (int i = 0; i < N_CH; i++) cyc(1'b1, 1'b1, 4 + i, 32'($urandom_range(1, 255)));
    cyc(1'b1, 1'b1, 0, 32'd1);
    idle(300);
    cs = 1'b1; we = 1'b0; a = 32'd0; wd = 32'd0;
    reset = 1'b0;
    model_reset();
    e.led = m_led; e.rd = model_rd(0); e.cyc = cyc_no;
    sb_q.push_back(e);
    @(posedge clk);
    model_step(1'b1, 1'b0, 0, 32'd0);
    cyc_no++;
    #1;
    reset = 1'b1;
    idle(10);
    for (int o = 0; o < 12; o++) cyc(1'b1, 1'b0, o, 32'd0);
    idle(5);

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) chk("scoreboard_drain", 32'(sb_q.size()), 32'd0, cyc_no);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/led_pwm_bank.md
Name: led_pwm_bank

Overview:
- Memory-mapped LED controller; successor of the single 8-bit LED register on the data bus.
- Drives N_CH LED outputs. Each channel has its own mode: off, static on, PWM dimming or blink.
- All channels share one prescaled PWM timebase. Duty values are double-buffered so a duty change never causes an output glitch.
- Sits behind the chip-select decode on the processor data bus, in the LED window. Reads are combinational, matching the other bus slaves.

Parameters:
- N_CH, 8, number of LED channels (1..8).
- DUTY_W, 8, PWM counter and duty width; PWM period is 2^DUTY_W ticks.
- PRESC_W, 16, prescaler register width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- cs  in  1  chip select from the address decode.
- we  in  1  write strobe; a write happens only when cs & we.
- a  in  32  byte address; only a[5:2] is decoded.
- wd  in  32  write data.
- rd  out  32  read data; combinational from a; 0 when cs=0.
- led  out  N_CH  LED outputs, registered.

Behaviour:
- Register map (word offset a[5:2]):
  - 0 CTRL: bit0 EN. Other bits read 0.
  - 1 PRESC: PRESC_W bits. Timebase tick every PRESC+1 clocks.
  - 2 MODE: 2 bits per channel, ch i at [2i+1:2i]. 00 off, 01 on, 10 PWM, 11 blink.
  - 3 BLINK: 16 bits. Blink half-period, in PWM periods, minus 1.
  - 4..4+N_CH-1 DUTY[i]: DUTY_W bits. Reads return the written value, not the shadow.
  - Unmapped offsets: reads return 0, writes are ignored.
- Writes: every register updates on the clk edge where cs & we. Upper unused bits are dropped.
- Reset (reset=0, asynchronous): all registers, shadows and counters go to 0; led=0; blink phase=0.
- Prescaler:
  - psc counts 0..PRESC. tick=1 for one clock when psc==PRESC, then psc returns to 0.
  - PRESC=0 gives a tick every clock.
  - If PRESC is written below the current psc, the next clock restarts psc at 0.
- PWM counter: pc (DUTY_W bits) increments on each tick and wraps from 2^DUTY_W-1 to 0. wrap = tick & (pc==all-ones).
- Duty shadow: dsh[i] <= DUTY[i] on wrap only. Writes to DUTY take effect at the next period boundary.
- Blink:
  - bc counts PWM periods on wrap, 0..BLINK. When bc==BLINK on a wrap, bc goes to 0 and phase toggles.
- Per-channel next value:
  - off -> 0.
  - on -> 1.
  - PWM -> (pc < dsh[i]). Duty 0 gives always 0; all-ones gives high for 2^DUTY_W-1 of 2^DUTY_W ticks.
  - blink -> phase.
- led is registered from the next value, so it lags counter state by 1 clock.
- EN=0: psc, pc, bc, phase and shadows are held at 0, and led=0 for every mode.
  - EN 0->1: counting starts the next clock with pc=0.
  - The shadow loads DUTY on the first clock with EN=1, treated as a wrap.
- Simultaneous write and wrap: a DUTY write in the same cycle as a wrap is not captured by that wrap. The shadow takes the old value; the new value loads at the following wrap.
- A MODE change applies on the next clock, without waiting for a period boundary.
- Reset asserted mid-period clears everything immediately; nothing is retained.

Test Plan:
1. Reset values: after reset release, read offsets 0..11 -> all 0; led=0 for 10 clocks.
2. Static on: MODE=0x0001, EN=1 -> led[0]=1 exactly 1 clock after the EN write cycle; other channels 0; EN=0 -> led=0 on the next clock.
3. PWM: DUTY_W=8, PRESC=0, DUTY[2]=64, MODE ch2=10, EN=1 -> led[2] high for 64 of every 256 clocks, measured over 4 periods; DUTY=0 -> never high; DUTY=255 -> high 255/256.
4. Glitch-free update: write DUTY[2]=200 mid-period while pc=100 -> current period stays at 64 high clocks; next period is 200; a write in the same cycle as wrap takes effect one period later.
5. Blink: PRESC=0, BLINK=1, MODE ch1=11 -> led[1] toggles every 512 clocks.
6. Async reset mid-PWM: assert reset with no clock edge -> led=0 and rd(CTRL)=0 immediately; after release, led stays 0 until EN is rewritten.
